// File: rtl/video_scan_pkg.sv
// video_scan_pkg: raster timing and framebuffer placement shared by the
// controller and the top-level SRAM address mux.
package video_scan_pkg;
    typedef struct packed {
        int          h_act;
        int          h_fp;
        int          h_sync;
        int          h_bp;
        int          v_act;
        int          v_fp;
        int          v_sync;
        int          v_bp;
        logic [21:0] base;
    } timing_t;

    localparam timing_t XGA_60 = '{h_act: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
                                   v_act: 768, v_fp: 3, v_sync: 6, v_bp: 29,
                                   base: 22'h039FC0};

    function automatic int h_tot(timing_t t);
        return t.h_act + t.h_fp + t.h_sync + t.h_bp;
    endfunction

    function automatic int v_tot(timing_t t);
        return t.v_act + t.v_fp + t.v_sync + t.v_bp;
    endfunction

    function automatic int wpl(timing_t t);
        return t.h_act / 32;
    endfunction

    // Top display line sits at the highest addresses of the framebuffer.
    function automatic logic [21:0] fb_top(timing_t t);
        return t.base + 22'((t.v_act - 1) * wpl(t));
    endfunction

    localparam int          H_TOT = h_tot(XGA_60);
    localparam int          V_TOT = v_tot(XGA_60);
    localparam int          WPL   = wpl(XGA_60);
    localparam logic [21:0] BASE  = XGA_60.base;
endpackage

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters, sync/active decode and framebuffer
// fetch strobes, all decoded from the current counter state.
module video_timing_gen
    import video_scan_pkg::*;
#(
    parameter timing_t T = XGA_60
) (
    input  logic clk,
    input  logic rst,
    output logic active_o,
    output logic hsync_n_o,
    output logic vsync_n_o,
    output logic load_o,
    output logic fetch_o,
    output logic first_o,
    output logic last_o,
    output logic reload_o
);
    localparam int HT = h_tot(T);
    localparam int VT = v_tot(T);
    localparam int HW = $clog2(HT + 1);
    localparam int VW = $clog2(VT + 1);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          hwrap, pre, mid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    always_comb begin
        hwrap     = hcnt_q == HW'(HT - 1);
        hcnt_d    = hwrap ? '0 : hcnt_q + HW'(1);
        vcnt_d    = !hwrap ? vcnt_q : vcnt_q == VW'(VT - 1) ? '0 : vcnt_q + VW'(1);
        active_o  = hcnt_q < HW'(T.h_act) && vcnt_q < VW'(T.v_act);
        hsync_n_o = !(hcnt_q >= HW'(T.h_act + T.h_fp) && hcnt_q < HW'(T.h_act + T.h_fp + T.h_sync));
        vsync_n_o = !(vcnt_q >= VW'(T.v_act + T.v_fp) && vcnt_q < VW'(T.v_act + T.v_fp + T.v_sync));
        load_o    = active_o && hcnt_q[4:0] == 5'd0;
        // Word 0 of the next line is prefetched near the end of the current one.
        first_o   = hcnt_q == HW'(HT - 16) && vcnt_q == VW'(VT - 1);
        pre       = hcnt_q == HW'(HT - 16) && (vcnt_q < VW'(T.v_act - 1) || first_o);
        mid       = vcnt_q < VW'(T.v_act) && hcnt_q[4:0] == 5'd16 && hcnt_q <= HW'(T.h_act - 48);
        fetch_o   = pre || mid;
        last_o    = hcnt_q == HW'(T.h_act - 48);
        reload_o  = hcnt_q == '0 && vcnt_q == VW'(T.v_act);
    end
endmodule

// File: rtl/video_scan_ctrl.sv
// video_scan_ctrl: monochrome raster controller stealing one SRAM cycle per
// 32 pixels; fetch pointer, word buffer and pixel shifter live here.
module video_scan_ctrl
    import video_scan_pkg::*;
#(
    parameter timing_t T = XGA_60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inv_i,
    input  logic [31:0] viddata_i,
    output logic        req_o,
    output logic [21:0] vidadr_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic        pix_o
);
    localparam logic [21:0] TOP       = fb_top(T);
    localparam logic [21:0] LINE_BACK = 22'(2 * wpl(T) - 1);

    logic        active, hsync_n, vsync_n, load, fetch, first, last, reload;
    logic        primed_q, primed_d;
    logic [21:0] ptr_q, ptr_d;
    logic [31:0] buf_q, buf_d, sh_q, sh_d;
    logic        hs_q, vs_q, de_q, pix_q, pix_d;

    video_timing_gen #(.T(T)) u_timing (
        .clk       (clk),
        .rst       (rst),
        .active_o  (active),
        .hsync_n_o (hsync_n),
        .vsync_n_o (vsync_n),
        .load_o    (load),
        .fetch_o   (fetch),
        .first_o   (first),
        .last_o    (last),
        .reload_o  (reload)
    );

    // Fetching stays off after reset until the line-0 prefetch of a whole frame.
    always_comb begin
        req_o    = rst && fetch && (primed_q || first);
        primed_d = primed_q || first;
        ptr_d    = req_o ? (last ? ptr_q - LINE_BACK : ptr_q + 22'd1) : reload ? TOP : ptr_q;
        buf_d    = req_o ? viddata_i : buf_q;
        sh_d     = load ? buf_q : sh_q >> 1;
        pix_d    = active && (sh_d[0] ^ inv_i);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            primed_q <= 1'b0;
            ptr_q    <= TOP;
            buf_q    <= '0;
            sh_q     <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            de_q     <= 1'b0;
            pix_q    <= 1'b0;
        end else begin
            primed_q <= primed_d;
            ptr_q    <= ptr_d;
            buf_q    <= buf_d;
            sh_q     <= sh_d;
            hs_q     <= hsync_n;
            vs_q     <= vsync_n;
            de_q     <= active;
            pix_q    <= pix_d;
        end
    end

    assign vidadr_o = ptr_q;
    assign hsync_o  = hs_q;
    assign vsync_o  = vs_q;
    assign de_o     = de_q;
    assign pix_o    = pix_q;
endmodule

// File: doc/video_scan_ctrl.md
Name: video_scan_ctrl

Overview:
- Monochrome raster display controller sitting beside the RISC5 core on the shared single-cycle SRAM bus.
- Generates 1024x768@60 timing and steals one bus cycle per 32 pixels to fetch framebuffer words.
- Its `req` output drives the core's `stallX`. While `req`=1 the top level muxes `vidadr` onto the SRAM address and returns the word on `viddata` in the same cycle.

Parameters:
- H_ACT, 1024, active pixels per line (multiple of 32)
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, hsync width
- H_BP, 160, horizontal back porch
- V_ACT, 768, active lines
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width
- V_BP, 29, vertical back porch
- BASE, 22'h039FC0, framebuffer word address of bottom-left word

Ports:
- clk  in  1  system clock = pixel clock, one pixel per cycle
- rst  in  1  synchronous reset, active-low
- inv  in  1  invert video
- viddata  in  32  framebuffer word, valid in the cycle `req`=1
- req  out  1  bus-steal request, routed to stallX
- vidadr  out  22  framebuffer word address, meaningful when `req`=1
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- de  out  1  display enable (active pixel)
- pix  out  1  pixel value

Behaviour:
- Constants:
  - H_TOT = H_ACT+H_FP+H_SYNC+H_BP (default 1344).
  - V_TOT = V_ACT+V_FP+V_SYNC+V_BP (default 806).
  - WPL = H_ACT/32.
- Counters:
  - hcnt 0..H_TOT-1, increments every clk and wraps to 0.
  - vcnt increments when hcnt wraps, 0..V_TOT-1, and wraps to 0.
- Reset (`rst`=0 at a clk edge):
  - hcnt=0, vcnt=0, shift register=0, buffer=0, pointer=start-of-frame value.
  - Outputs: req=0, hsync=1, vsync=1, de=0, pix=0.
  - Reset mid-frame abandons the frame; the first frame after release starts at line 0.
- Active region: hcnt<H_ACT and vcnt<V_ACT.
- Sync decode:
  - hsync is low for H_ACT+H_FP <= hcnt < H_ACT+H_FP+H_SYNC.
  - vsync is low for V_ACT+V_FP <= vcnt < V_ACT+V_FP+V_SYNC.
- Fetch schedule (req high exactly one cycle per fetch, never two consecutive cycles):
  - word 0 of line y is fetched at hcnt==H_TOT-16 of the preceding line, when (vcnt+1) mod V_TOT < V_ACT;
  - word k+1 is fetched at hcnt==32k+16 for k=0..WPL-2, when vcnt<V_ACT.
- Addressing:
  - Line y (0=top), word k is at BASE + (V_ACT-1-y)*WPL + k; the top line is at the highest addresses.
  - vidadr is driven from a register and is stable for the whole req cycle.
  - Implement as an incrementing pointer: load at frame start, +1 per fetch, -2*WPL after the last word of a line.
- Buffering: viddata is captured into a 32-bit buffer at the end of the req cycle.
- Pixel shift: at hcnt==32k (active line, k<WPL) the buffer is loaded into the shift register; otherwise the shift register shifts right 1 each cycle.
- Bit order: word bit 0 is the leftmost pixel.
- Outputs registered, latency 1: hsync/vsync/de/pix reflect the counter state of the previous cycle, so all four stay aligned.
- Pixel value: pix = de ? (shreg[0]^inv) : 0.
- inv: sampled every cycle; a change takes effect on the next pixel.
- Bandwidth: WPL*V_ACT = 24576 req cycles per frame; the CPU sees exactly those stall cycles.

Decomposition:
- Shared package holds the timing constants (H_ACT..V_BP, derived H_TOT/V_TOT/WPL) and BASE, so the top-level address mux and the memory map agree.
- One natural sub-module: video_timing_gen (hcnt/vcnt, hsync/vsync/de decode, fetch strobes).
- Fetch pointer, buffer and shift register stay in video_scan_ctrl.

Test Plan:
1. Reset behaviour: hold rst=0 for 5 clks, then release -> during reset req=0, hsync=1, vsync=1, de=0, pix=0. First de=1 appears 1 clk after hcnt=0 of line 0 following release, or at frame wrap.
2. Sync timing: free-run 2 lines -> hsync low for exactly 136 clks starting 1048 clks after de rises; line period 1344 clks; vsync low for exactly 6 lines, 771 lines after frame start; frame = 806*1344 clks.
3. Address sequence: record vidadr at each req over one frame -> first fetch of the frame = 22'h03FFA0 (line 0 word 0), next = 22'h03FFA1; line 1 word 0 = 22'h03FF80; last fetch = 22'h039FDF; total 24576 reqs; no req in lines 768..805 except the line-0 prefetch at line 805, hcnt 1328.
4. Pixel order: viddata=32'h00000001 for word 0 and 0 elsewhere -> pix=1 only at the first active pixel of each line. viddata=32'h80000000 -> pix=1 at pixel 31 only.
5. Invert: inv=1 with viddata=0 -> pix=1 for all 1024 active pixels and pix=0 in blanking. Toggling inv mid-line flips pix from the next pixel.
6. Reset mid-frame: assert rst=0 for 1 clk at vcnt=400, hcnt=500 -> req drops that cycle. After release the first fetch address is 22'h03FFA0, fetched at hcnt=1328 of line 805.
